work_transmit: RTL and testbench
================================

# work_transmit

Serializes one 64-byte work frame (256-bit midstate, 160 zero pad bits, 96-bit data2) onto a UART line, most significant byte first. It is the sending end of the host-to-FPGA work protocol, used on the master FPGA to forward work to a chained FPGA whose work receiver reassembles the same 512-bit buffer. Byte serialization is delegated to the existing `async_transmitter`.

## Interface

Parameters:
- `GAP_CYCLES`, default 0: idle clk cycles inserted after each byte completes, before the next start. Must be below 2^22-1, the downstream receiver idle guard.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `midstate`, input, 256: work midstate. Sampled on an accepted `send`.
- `data2`, input, 96: work tail data. Sampled on an accepted `send`.
- `send`, input, 1: request a frame. Accepted only when `busy`=0.
- `busy`, output, 1: frame in progress. Reset value 0.
- `done`, output, 1: one-cycle pulse when the last byte has finished. Reset value 0.
- `TxD`, output, 1: serial line. Idles high and is driven by `async_transmitter`.

## Operation

- Frame buffer `frame[511:0]` = {midstate, 160'b0, data2}.
  - Bytes 0–31: midstate[255:248] first.
  - Bytes 32–51: 0x00.
  - Bytes 52–63: data2[95:88] first.
  - The receiver shifts each byte in at the LSB, so it ends with midstate in [511:256] and data2 in [95:0].
- Byte counter: 6 bits, 0..63. No wrap inside a frame; the frame ends when byte 63 completes.
- FSM states:
  - IDLE: `busy`=0. If `send`=1, latch the frame, clear the counter, go to START.
  - START: drive `TxD_start`=1 with `TxD_data`=frame[511:504]. Hold both until `TxD_busy`=1 is sampled, then go to WAIT.
  - WAIT: `TxD_start`=0. On `TxD_busy`=0:
    - if the counter is 63, go to DONE;
    - otherwise shift `frame` left by 8, increment the counter, and go to GAP (or START if `GAP_CYCLES`=0).
  - GAP: count `GAP_CYCLES` cycles, then go to START.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `send` while `busy`=1 is ignored, with no queuing. Inputs may change freely after acceptance.
- `reset` mid-frame:
  - FSM goes to IDLE, the counter clears, `busy` and `done` are 0 on the next cycle.
  - A byte already in `async_transmitter` completes on the line, because that block has no reset.
  - The next frame's START waits for `TxD_busy` to rise from an idle transmitter, so that byte is never corrupted.
  - Partial-frame recovery downstream relies on the receiver guard timeout. The block does not pad truncated frames.
- `reset` has priority over `send` in the same cycle.

## Timing

- `send`=1 sampled in IDLE at edge N: `busy`=1 and `TxD_start`=1 from N+1.
- Start bit appears on `TxD` per `async_transmitter` latency, nominally one cycle after `TxD_start`.
- Per-byte period = `async_transmitter` busy time + 2 handshake cycles + `GAP_CYCLES`.
- `done` pulses in the cycle after the `TxD_busy` fall for byte 63. `busy` falls on the following cycle.
- A `send` held high continuously starts the next frame on the first cycle back in IDLE. The back-to-back gap is ≥1 cycle plus stop bit.
- No combinational path from `send` to any output.

## Structure

Shared package `work_proto_pkg` holds:
- `FRAME_BYTES`=64, `MIDSTATE_BYTES`=32, `PAD_BYTES`=20, `DATA2_BYTES`=12.
- `RX_GUARD_BITS`=22.
- FSM state enum {IDLE, START, WAIT, GAP, DONE}.

The receiver side uses the same package. The single sub-module is `async_transmitter`, instantiated unchanged. Framing, FSM and gap counter live in `work_transmit`.

## Test plan

- Basic frame: midstate=256'h0001…1F (byte i = i), data2=96'hA0A1…AB, `send` pulse.
  - Required: UART bytes 00..1F, twenty 00, then A0..AB.
  - Exactly one `done`; `busy` is high the whole frame.
  - Loopback through the work receiver yields identical midstate and data2.
- Send while busy: second `send` at byte 10 with different data.
  - Required: ignored. Frame content unchanged, exactly 64 bytes, one `done`.
- Back-to-back: `send` held high for two frames.
  - Required: 128 bytes, two `done` pulses, second frame uses values sampled at its own acceptance.
- Reset mid-frame at byte 20, then a new `send` of all-FF midstate, data2=0.
  - Required: `busy`=0 one cycle after reset; in-flight byte completes cleanly.
  - After the receiver guard idle time, the new frame is received intact.
- `GAP_CYCLES`=1000.
  - Required: measured idle between each stop bit and the next start bit is ≥1000 cycles; content identical to the basic test.
- Reset and `send` in the same cycle.
  - Required: `busy` stays 0 and no start bit appears.

Source files
------------

// File: rtl/work_proto_pkg.sv
// rtl/work_proto_pkg.sv - Shared constants and state encoding for the work frame protocol
package work_proto_pkg;

  localparam int FRAME_BYTES    = 64;
  localparam int MIDSTATE_BYTES = 32;
  localparam int PAD_BYTES      = 20;
  localparam int DATA2_BYTES    = 12;
  localparam int FRAME_BITS     = FRAME_BYTES * 8;
  localparam int RX_GUARD_BITS  = 22;

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE} work_state_e;

  // Frame layout shared by transmitter and receiver: midstate on top, data2 in the low bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [MIDSTATE_BYTES*8-1:0] midstate,
    input logic [DATA2_BYTES*8-1:0]    data2
  );
    return {midstate, {(PAD_BYTES*8){1'b0}}, data2};
  endfunction

endpackage

// File: rtl/async_transmitter.sv
// rtl/async_transmitter.sv - 8N1 UART byte transmitter, LSB first, no reset
module async_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  // Power-up values stand in for a reset so the line idles high from configuration.
  logic             busy_q  = 1'b0;
  logic [3:0]       bit_q   = '0;
  logic [DIV_W-1:0] div_q   = '0;
  logic [9:0]       shift_q = '1;

  always_ff @(posedge clk) begin
    if (!busy_q) begin
      if (TxD_start) begin
        busy_q  <= 1'b1;
        shift_q <= {1'b1, TxD_data, 1'b0};
        bit_q   <= '0;
        div_q   <= '0;
      end
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      shift_q <= {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        bit_q <= bit_q + 4'd1;
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign TxD      = shift_q[0];
  assign TxD_busy = busy_q;

endmodule

// File: rtl/work_transmit.sv
// rtl/work_transmit.sv - Serializes a 64-byte work frame MSB-first through async_transmitter
module work_transmit
  import work_proto_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] midstate,
  input  logic [95:0]  data2,
  input  logic         send,
  output logic         busy,
  output logic         done,
  output logic         TxD
);

  localparam logic [5:0] LAST_BYTE = 6'(FRAME_BYTES - 1);
  localparam logic [RX_GUARD_BITS-1:0] GAP_LAST =
    RX_GUARD_BITS'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [RX_GUARD_BITS-1:0] GAP_ONE = RX_GUARD_BITS'(1);

  work_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]    frame_q, frame_d;
  logic [5:0]               byte_q, byte_d;
  logic [RX_GUARD_BITS-1:0] gap_q, gap_d;
  logic                     txd_busy_q;
  logic                     txd_start;
  logic                     txd_busy;
  logic [7:0]               txd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
    end
  end

  // Left unreset on purpose: the transmitter keeps running through reset and
  // START must see a genuine rising edge of its busy flag.
  always_ff @(posedge clk) begin
    txd_busy_q <= txd_busy;
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    busy      = 1'b1;
    done      = 1'b0;
    txd_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (send) begin
          frame_d = build_frame(midstate, data2);
          byte_d  = '0;
          state_d = START;
        end
      end
      START: begin
        txd_start = 1'b1;
        if (txd_busy && !txd_busy_q) state_d = WAIT;
      end
      WAIT: begin
        if (!txd_busy) begin
          if (byte_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            frame_d = {frame_q[FRAME_BITS-9:0], 8'h00};
            byte_d  = byte_q + 6'd1;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? START : GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = START;
        else                   gap_d   = gap_q + GAP_ONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign txd_data = frame_q[FRAME_BITS-1 -: 8];

  async_transmitter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .TxD_start(txd_start),
    .TxD_data (txd_data),
    .TxD      (TxD),
    .TxD_busy (txd_busy)
  );

endmodule

// File: tb/tb_work_transmit.sv
// tb/tb_work_transmit.sv - Directed self-checking bench for work_transmit
module tb_work_transmit;

  localparam int CPB      = 4;
  localparam int GAP_N    = 100;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int PER0     = BYTE_CYC + 2;
  localparam int PERG     = BYTE_CYC + 2 + GAP_N;
  localparam int FRAME0   = 64 * PER0 + 1;
  localparam int FRAMEG   = 64 * PER0 + 63 * GAP_N + 1;

  typedef struct {
    logic [255:0] ms;
    logic [95:0]  d2;
    logic [7:0]   b0, b31, b32, b52, b63;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [255:0] midstate = '0;
  logic [95:0] data2 = '0;
  logic send = 1'b0, send_g = 1'b0;
  logic busy, done, txd, busy_g, done_g, txd_g;

  int cyc = 0;
  int n_chk = 0, n_err = 0;
  int done_cnt = 0, busy_cnt = 0, done_cnt_g = 0, busy_cnt_g = 0;
  int stop_err = 0, stop_err_g = 0;
  logic [7:0] rxq[$], rxq_g[$];
  int rxt[$], rxt_g[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  work_transmit #(.GAP_CYCLES(0), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .midstate(midstate), .data2(data2), .send(send),
    .busy(busy), .done(done), .TxD(txd));

  work_transmit #(.GAP_CYCLES(GAP_N), .CLKS_PER_BIT(CPB)) dut_g (
    .clk(clk), .reset(reset), .midstate(midstate), .data2(data2), .send(send_g),
    .busy(busy_g), .done(done_g), .TxD(txd_g));

  always @(negedge clk) begin
    if (done === 1'b1)   done_cnt   <= done_cnt + 1;
    if (busy === 1'b1)   busy_cnt   <= busy_cnt + 1;
    if (done_g === 1'b1) done_cnt_g <= done_cnt_g + 1;
    if (busy_g === 1'b1) busy_cnt_g <= busy_cnt_g + 1;
  end

  function automatic logic line_of(input int which);
    return (which != 0) ? txd_g : txd;
  endfunction

  // UART receiver: samples mid-bit, records the cycle the start bit was first seen.
  task automatic rx_byte(input int which, output logic [7:0] b, output int t0, output logic ok);
    while (line_of(which) !== 1'b0) @(negedge clk);
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = line_of(which);
    end
    repeat (CPB) @(negedge clk);
    ok = (line_of(which) === 1'b1);
  endtask

  always begin : mon0
    logic [7:0] b; int t; logic ok;
    rx_byte(0, b, t, ok);
    rxq.push_back(b);
    rxt.push_back(t);
    if (!ok) stop_err <= stop_err + 1;
  end

  always begin : mon1
    logic [7:0] b; int t; logic ok;
    rx_byte(1, b, t, ok);
    rxq_g.push_back(b);
    rxt_g.push_back(t);
    if (!ok) stop_err_g <= stop_err_g + 1;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int which, input int i);
    return (which != 0) ? rxq_g[i] : rxq[i];
  endfunction

  function automatic int t_at(input int which, input int i);
    return (which != 0) ? rxt_g[i] : rxt[i];
  endfunction

  function automatic int done_of(input int which);
    return (which != 0) ? done_cnt_g : done_cnt;
  endfunction

  // Reassemble as the downstream receiver does: each byte shifted in at the LSB.
  task automatic check_frame(input string tag, input int which, input int first,
                             input logic [255:0] ms, input logic [95:0] d2);
    logic [511:0] r;
    int per_bad;
    int per;
    r = '0;
    per_bad = 0;
    per = (which != 0) ? PERG : PER0;
    for (int k = 0; k < 64; k++) r = {r[503:0], byte_at(which, first + k)};
    chk({tag, "_midstate"}, r[511:256], ms);
    chk({tag, "_pad"}, r[255:96], 0);
    chk({tag, "_data2"}, r[95:0], d2);
    for (int k = 1; k < 64; k++)
      if (t_at(which, first + k) - t_at(which, first + k - 1) != per) per_bad++;
    chk({tag, "_period_errs"}, per_bad, 0);
  endtask

  task automatic wait_done(input int which, input int target, input int budget, input string tag);
    for (int i = 0; i < budget && done_of(which) < target; i++) @(negedge clk);
    chk({tag, "_done_seen"}, done_of(which) >= target, 1);
  endtask

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[4];
    int q0, d0, bz0, c0, min_idle;
    vecs[0] = '{256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F,
                96'hA0A1A2A3A4A5A6A7A8A9AAAB, 8'h00, 8'h1F, 8'h00, 8'hA0, 8'hAB};
    vecs[1] = '{{256{1'b1}}, 96'h0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{{32{8'h5A}}, 96'h0123456789ABCDEF00112233, 8'h5A, 8'h5A, 8'h00, 8'h01, 8'h33};
    vecs[3] = '{{8'h80, 240'h0, 8'h01}, {8'h80, 80'h0, 8'h01}, 8'h80, 8'h01, 8'h00, 8'h80, 8'h01};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_txd", txd, 1);
    chk("rst_busy_g", busy_g, 0);
    chk("rst_done_g", done_g, 0);
    chk("rst_txd_g", txd_g, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      q0 = rxq.size(); d0 = done_cnt; bz0 = busy_cnt;
      @(negedge clk);
      midstate = vecs[v].ms; data2 = vecs[v].d2; send = 1'b1; c0 = cyc;
      @(negedge clk);
      send = 1'b0; midstate = ~vecs[v].ms; data2 = ~vecs[v].d2;
      chk($sformatf("v%0d_busy_rise", v), busy, 1);
      wait_done(0, d0 + 1, 4000, $sformatf("v%0d", v));
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_done_cnt", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_busy_cycles", v), busy_cnt - bz0, FRAME0);
      chk($sformatf("v%0d_nbytes", v), rxq.size() - q0, 64);
      chk($sformatf("v%0d_start_lat", v), rxt[q0] - c0, 2);
      chk($sformatf("v%0d_b0", v), rxq[q0], vecs[v].b0);
      chk($sformatf("v%0d_b31", v), rxq[q0 + 31], vecs[v].b31);
      chk($sformatf("v%0d_b32", v), rxq[q0 + 32], vecs[v].b32);
      chk($sformatf("v%0d_b52", v), rxq[q0 + 52], vecs[v].b52);
      chk($sformatf("v%0d_b63", v), rxq[q0 + 63], vecs[v].b63);
      check_frame($sformatf("v%0d", v), 0, q0, vecs[v].ms, vecs[v].d2);
    end

    // send while busy is ignored
    q0 = rxq.size(); d0 = done_cnt;
    @(negedge clk); midstate = vecs[0].ms; data2 = vecs[0].d2; send = 1'b1;
    @(negedge clk); send = 1'b0;
    for (int i = 0; i < 2000 && rxq.size() < q0 + 10; i++) @(negedge clk);
    chk("busy_send_reach_b10", rxq.size() >= q0 + 10, 1);
    midstate = vecs[1].ms; data2 = vecs[1].d2; send = 1'b1;
    @(negedge clk); send = 1'b0;
    wait_done(0, d0 + 1, 4000, "busy_send");
    repeat (200) @(negedge clk);
    chk("busy_send_done_cnt", done_cnt - d0, 1);
    chk("busy_send_nbytes", rxq.size() - q0, 64);
    check_frame("busy_send", 0, q0, vecs[0].ms, vecs[0].d2);

    // back-to-back with send held high
    q0 = rxq.size(); d0 = done_cnt; bz0 = busy_cnt;
    @(negedge clk); midstate = vecs[2].ms; data2 = vecs[2].d2; send = 1'b1;
    @(negedge clk); midstate = vecs[3].ms; data2 = vecs[3].d2;
    wait_done(0, d0 + 1, 4000, "b2b_first");
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    send = 1'b0;
    wait_done(0, d0 + 2, 4000, "b2b_second");
    repeat (200) @(negedge clk);
    chk("b2b_done_cnt", done_cnt - d0, 2);
    chk("b2b_nbytes", rxq.size() - q0, 128);
    chk("b2b_busy_cycles", busy_cnt - bz0, 2 * FRAME0);
    check_frame("b2b_f1", 0, q0, vecs[2].ms, vecs[2].d2);
    check_frame("b2b_f2", 0, q0 + 64, vecs[3].ms, vecs[3].d2);

    // reset in the middle of byte 20, then a new frame while that byte drains
    q0 = rxq.size(); d0 = done_cnt;
    @(negedge clk); midstate = vecs[0].ms; data2 = vecs[0].d2; send = 1'b1;
    @(negedge clk); send = 1'b0;
    for (int i = 0; i < 2000 && rxq.size() < q0 + 20; i++) @(negedge clk);
    chk("rstmid_reach_b20", rxq.size() >= q0 + 20, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    midstate = vecs[1].ms; data2 = vecs[1].d2; send = 1'b1;
    @(negedge clk); send = 1'b0;
    wait_done(0, d0 + 1, 4000, "rstmid");
    repeat (10) @(negedge clk);
    chk("rstmid_done_cnt", done_cnt - d0, 1);
    chk("rstmid_nbytes", rxq.size() - q0, 85);
    chk("rstmid_inflight_byte", rxq[q0 + 20], 8'h14);
    chk("rstmid_stop_bits", stop_err, 0);
    check_frame("rstmid_new", 0, q0 + 21, vecs[1].ms, vecs[1].d2);

    // reset and send in the same cycle
    q0 = rxq.size();
    @(negedge clk); reset = 1'b1; send = 1'b1; midstate = vecs[2].ms;
    @(negedge clk);
    chk("rstsend_busy", busy, 0);
    reset = 1'b0; send = 1'b0;
    repeat (60) @(negedge clk);
    chk("rstsend_busy_later", busy, 0);
    chk("rstsend_no_bytes", rxq.size() - q0, 0);
    chk("rstsend_txd", txd, 1);

    // inter-byte gap
    q0 = rxq_g.size(); d0 = done_cnt_g; bz0 = busy_cnt_g;
    @(negedge clk); midstate = vecs[0].ms; data2 = vecs[0].d2; send_g = 1'b1;
    @(negedge clk); send_g = 1'b0;
    wait_done(1, d0 + 1, 12000, "gap");
    repeat (10) @(negedge clk);
    chk("gap_done_cnt", done_cnt_g - d0, 1);
    chk("gap_busy_cycles", busy_cnt_g - bz0, FRAMEG);
    chk("gap_nbytes", rxq_g.size() - q0, 64);
    chk("gap_stop_bits", stop_err_g, 0);
    min_idle = 1000000;
    for (int k = 1; k < 64; k++)
      if (rxt_g[q0 + k] - (rxt_g[q0 + k - 1] + BYTE_CYC) < min_idle)
        min_idle = rxt_g[q0 + k] - (rxt_g[q0 + k - 1] + BYTE_CYC);
    chk("gap_min_idle_ok", min_idle >= GAP_N, 1);
    check_frame("gap", 1, q0, vecs[0].ms, vecs[0].d2);

    chk("stop_bits_total", stop_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
